adam_debug_jtag_tap: RTL and testbench



---
 rtl/adam_debug_jtag_pkg.sv | 56 +++++
 rtl/adam_debug_jtag_sync.sv | 50 +++++
 rtl/adam_debug_jtag_tap.sv | 144 ++++++++++++++
 tb/tb_adam_debug_jtag_tap.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adam_debug_jtag_pkg.sv
// JTAG TAP shared types: state encoding, IR codes
// and the 1149.1 next-state function.
package adam_debug_jtag_pkg;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPD_DR,
    SEL_IR,
    CAP_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPD_IR
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_BYPASS  = 5'h1F;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

  function automatic tap_state_e tap_next(
    input tap_state_e s,
    input logic       tms
  );
    tap_state_e n;
    n = TLR;
    unique case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/adam_debug_jtag_sync.sv
// JTAG pin synchronizer: SYNC_STAGES flops per pin
// plus single-cycle tck edge pulses.
module adam_debug_jtag_sync
  import adam_debug_jtag_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trst_n,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic trst_n_s,
  output logic tms_s,
  output logic tdi_s,
  output logic tck_rise,
  output logic tck_fall
);

  logic [SYNC_STAGES-1:0] trst_q;
  logic [SYNC_STAGES-1:0] tck_q;
  logic [SYNC_STAGES-1:0] tms_q;
  logic [SYNC_STAGES-1:0] tdi_q;
  logic                   tck_prev;

  // shift each pin through its synchronizer chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trst_q   <= '0;
      tck_q    <= '0;
      tms_q    <= '0;
      tdi_q    <= '0;
      tck_prev <= 1'b0;
    end else begin
      trst_q   <= {trst_q[SYNC_STAGES-2:0], trst_n};
      tck_q    <= {tck_q[SYNC_STAGES-2:0], tck};
      tms_q    <= {tms_q[SYNC_STAGES-2:0], tms};
      tdi_q    <= {tdi_q[SYNC_STAGES-2:0], tdi};
      tck_prev <= tck_q[SYNC_STAGES-1];
    end
  end

  assign trst_n_s = trst_q[SYNC_STAGES-1];
  assign tms_s    = tms_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_q[SYNC_STAGES-1];
  assign tck_rise = tck_q[SYNC_STAGES-1] & ~tck_prev;
  assign tck_fall = ~tck_q[SYNC_STAGES-1] & tck_prev;

endmodule

// File: rtl/adam_debug_jtag_tap.sv
// Oversampled JTAG TAP with IDCODE, BYPASS and one
// user DR exposed as a valid/ready request.
module adam_debug_jtag_tap
  import adam_debug_jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE        = 32'h0000_0001,
  parameter int          IR_WIDTH      = 5,
  parameter logic [IR_WIDTH-1:0] USER_IR = 5'h11,
  parameter int          USER_DR_WIDTH = 41,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trst_n,
  input  logic                     tck,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     user_req_valid,
  input  logic                     user_req_ready,
  output logic [USER_DR_WIDTH-1:0] user_req_data,
  input  logic [USER_DR_WIDTH-1:0] user_rsp_data,
  output logic                     user_err
);

  localparam int DR_W =
    (USER_DR_WIDTH > 32) ? USER_DR_WIDTH : 32;
  localparam logic [IR_WIDTH-1:0] IR_ID =
    IR_WIDTH'(IR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_BY = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAP =
    IR_WIDTH'(IR_CAPTURE);

  logic trst_n_s;
  logic tms_s;
  logic tdi_s;
  logic tck_rise;
  logic tck_fall;

  tap_state_e          state;
  tap_state_e          state_nxt;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [DR_W-1:0]     dr_sr;
  logic                sel_id;
  logic                sel_user;
  logic                ir_legal;
  logic                pending;

  adam_debug_jtag_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .trst_n   (trst_n),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .trst_n_s (trst_n_s),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  assign state_nxt = tap_next(state, tms_s);
  assign sel_id    = (ir == IR_ID);
  assign sel_user  = (ir == USER_IR);
  assign ir_legal  = (ir_sr == IR_ID) ||
                     (ir_sr == IR_BY) ||
                     (ir_sr == USER_IR);
  // an accept in this same cycle frees the slot
  assign pending   = user_req_valid & ~user_req_ready;

  // TAP state, IR/DR datapath, tdo and request handshake
  always_ff @(posedge clk) begin
    if (!rst_n || !trst_n_s) begin
      state          <= TLR;
      ir             <= IR_ID;
      ir_sr          <= '0;
      dr_sr          <= '0;
      tdo            <= 1'b0;
      user_req_valid <= 1'b0;
      user_req_data  <= '0;
      user_err       <= 1'b0;
    end else begin
      if (user_req_valid && user_req_ready) begin
        user_req_valid <= 1'b0;
      end
      if (tck_rise) begin
        state <= state_nxt;
        unique case (state)
          CAP_IR: ir_sr <= IR_CAP;
          SHIFT_IR: begin
            ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
          end
          UPD_IR: ir <= ir_legal ? ir_sr : IR_BY;
          CAP_DR: begin
            unique case (1'b1)
              sel_user: dr_sr <= DR_W'(user_rsp_data);
              sel_id:   dr_sr <= DR_W'(IDCODE);
              default:  dr_sr <= '0;
            endcase
          end
          SHIFT_DR: begin
            unique case (1'b1)
              sel_user: begin
                dr_sr[USER_DR_WIDTH-1:0] <=
                  {tdi_s, dr_sr[USER_DR_WIDTH-1:1]};
              end
              sel_id: begin
                dr_sr[31:0] <= {tdi_s, dr_sr[31:1]};
              end
              default: dr_sr[0] <= tdi_s;
            endcase
          end
          UPD_DR: begin
            if (sel_user) begin
              if (!pending) begin
                user_req_data  <= dr_sr[USER_DR_WIDTH-1:0];
                user_req_valid <= 1'b1;
              end else begin
                user_err <= 1'b1;
              end
            end
          end
          default: ;
        endcase
        if (state_nxt == TLR) begin
          ir       <= IR_ID;
          user_err <= 1'b0;
        end
      end
      if (tck_fall) begin
        unique case (state)
          SHIFT_IR: tdo <= ir_sr[0];
          SHIFT_DR: tdo <= dr_sr[0];
          default:  tdo <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adam_debug_jtag_tap.sv
// Directed bench for the JTAG TAP: IDCODE, BYPASS,
// IR capture, user DR handshake, overflow and trst.
module tb_adam_debug_jtag_tap;

  logic        clk;
  logic        rst_n;
  logic        trst_n;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic        user_req_valid;
  logic        user_req_ready;
  logic [40:0] user_req_data;
  logic [40:0] user_rsp_data;
  logic        user_err;

  int checks;
  int errors;
  int lo_clks;
  int hi_clks;

  adam_debug_jtag_tap dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trst_n         (trst_n),
    .tck            (tck),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .user_req_valid (user_req_valid),
    .user_req_ready (user_req_ready),
    .user_req_data  (user_req_data),
    .user_rsp_data  (user_rsp_data),
    .user_err       (user_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tdo sampled just before the rise it belongs to
  task automatic tick(
    input  logic t_ms,
    input  logic t_di,
    output logic t_do
  );
    repeat (lo_clks) @(posedge clk);
    #1;
    t_do = tdo;
    tms  = t_ms;
    tdi  = t_di;
    tck  = 1'b1;
    repeat (hi_clks) @(posedge clk);
    #1;
    tck = 1'b0;
  endtask

  task automatic scan_ir(
    input  logic [4:0] din,
    output logic [4:0] dout
  );
    logic d;
    tick(1'b1, 1'b0, d);
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
    tick(1'b0, 1'b0, d);
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, din[i], dout[i]);
    end
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
  endtask

  // from RTI into UPDATE_DR, update not yet taken
  task automatic scan_dr_upd(
    input  logic [63:0] din,
    input  int          n,
    output logic [63:0] dout
  );
    logic d;
    dout = '0;
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
    tick(1'b0, 1'b0, d);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], dout[i]);
    end
    tick(1'b1, 1'b0, d);
  endtask

  task automatic scan_dr(
    input  logic [63:0] din,
    input  int          n,
    output logic [63:0] dout
  );
    logic d;
    scan_dr_upd(din, n, dout);
    tick(1'b0, 1'b0, d);
  endtask

  task automatic drain;
    user_req_ready = 1'b1;
    @(posedge clk);
    #1;
    user_req_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    trst_n         = 1'b1;
    tck            = 1'b0;
    tms            = 1'b1;
    tdi            = 1'b0;
    user_req_ready = 1'b0;
    user_rsp_data  = '0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (tdo !== 1'b0) begin
      errors++;
      $display("FAIL reset_tdo got %b want 0", tdo);
    end
    checks++;
    if (user_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0",
               user_req_valid);
    end
    checks++;
    if (user_req_data !== 41'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
               user_req_data);
    end
    checks++;
    if (user_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", user_err);
    end
  endtask

  task automatic test_idcode;
    logic        d;
    logic [63:0] q;
    tick(1'b0, 1'b0, d);
    scan_dr(64'h0, 32, q);
    checks++;
    if (q[31:0] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL idcode got %h want 00000001",
               q[31:0]);
    end
  endtask

  task automatic test_bypass;
    logic [4:0]  qi;
    logic [63:0] q;
    scan_ir(5'h1F, qi);
    scan_dr(64'hD, 4, q);
    checks++;
    if (q[3:0] !== 4'b1010) begin
      errors++;
      $display("FAIL bypass got %b want 1010", q[3:0]);
    end
  endtask

  task automatic test_ir_capture;
    logic [4:0] qi;
    scan_ir(5'h1F, qi);
    checks++;
    if (qi !== 5'b00001) begin
      errors++;
      $display("FAIL ir_capture got %b want 00001", qi);
    end
  endtask

  task automatic test_user;
    logic [4:0]  qi;
    logic [63:0] q;
    user_rsp_data = 41'h1_2345_6789;
    scan_ir(5'h11, qi);
    scan_dr(64'h0_AAAA_5555, 41, q);
    checks++;
    if (q[40:0] !== 41'h1_2345_6789) begin
      errors++;
      $display("FAIL user_tdo got %h want 12345_6789",
               q[40:0]);
    end
    checks++;
    if (user_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL user_valid got %b want 1",
               user_req_valid);
    end
    checks++;
    if (user_req_data !== 41'h0_AAAA_5555) begin
      errors++;
      $display("FAIL user_data got %h want AAAA5555",
               user_req_data);
    end
    user_req_ready = 1'b1;
    #1;
    checks++;
    if (user_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL accept_same got %b want 1",
               user_req_valid);
    end
    @(posedge clk);
    #1;
    user_req_ready = 1'b0;
    checks++;
    if (user_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_next got %b want 0",
               user_req_valid);
    end
  endtask

  task automatic test_overflow;
    logic        d;
    logic [63:0] q;
    user_rsp_data = 41'h0;
    scan_dr(64'h155, 41, q);
    scan_dr(64'h0AA, 41, q);
    checks++;
    if (user_req_data !== 41'h155) begin
      errors++;
      $display("FAIL ovf_data got %h want 155",
               user_req_data);
    end
    checks++;
    if (user_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_err got %b want 1", user_err);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, d);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (user_err !== 1'b0) begin
      errors++;
      $display("FAIL tlr_err got %b want 0", user_err);
    end
    drain();
    tick(1'b0, 1'b0, d);
    scan_dr(64'h0, 32, q);
    checks++;
    if (q[31:0] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL tlr_ir got %h want 00000001",
               q[31:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0]  qi;
    logic [63:0] q;
    scan_ir(5'h11, qi);
    scan_dr(64'h1_0000_0001, 41, q);
    scan_dr_upd(64'h0_0000_00F0, 41, q);
    repeat (lo_clks) @(posedge clk);
    #1;
    tms = 1'b0;
    tck = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    user_req_ready = 1'b1;
    @(posedge clk);
    #1;
    user_req_ready = 1'b0;
    repeat (hi_clks) @(posedge clk);
    #1;
    tck = 1'b0;
    checks++;
    if (user_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_valid got %b want 1",
               user_req_valid);
    end
    checks++;
    if (user_req_data !== 41'h0F0) begin
      errors++;
      $display("FAIL b2b_data got %h want 0F0",
               user_req_data);
    end
    checks++;
    if (user_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err got %b want 0", user_err);
    end
    drain();
  endtask

  task automatic test_trst;
    logic        d;
    logic [4:0]  qi;
    logic [63:0] q;
    lo_clks = 3;
    hi_clks = 3;
    scan_ir(5'h11, qi);
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
    tick(1'b0, 1'b0, d);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, d);
    end
    repeat (2) @(posedge clk);
    #1;
    trst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    trst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (user_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL trst_valid got %b want 0",
               user_req_valid);
    end
    checks++;
    if (tdo !== 1'b0) begin
      errors++;
      $display("FAIL trst_tdo got %b want 0", tdo);
    end
    tick(1'b0, 1'b0, d);
    scan_dr(64'h0, 32, q);
    checks++;
    if (q[31:0] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL trst_idcode got %h want 00000001",
               q[31:0]);
    end
    checks++;
    if (user_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL trst_noreq got %b want 0",
               user_req_valid);
    end
    lo_clks = 4;
    hi_clks = 4;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    lo_clks = 4;
    hi_clks = 4;
    test_reset();
    test_idcode();
    test_bypass();
    test_ir_capture();
    test_user();
    test_overflow();
    test_back_to_back();
    test_trst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
